// File: rtl/int_src_conditioner.sv
// int_src_conditioner
// ---------------------------------------------------------------------------
// Turns raw, asynchronous interrupt lines from peripheral IPs into single-cycle
// event pulses for the external interrupt controller. Each source runs through
// a 2-flop synchronizer, a programmable debounce filter and an edge selector.
// A sticky, write-1-to-clear event register keeps a software-visible record.
//
// Register map (word offsets, only p_addr[3:0] decoded):
//   0x0 CFG  RW  2 bits per source: 00 off, 01 rising, 10 falling, 11 both
//   0x4 DEB  RW  debounce threshold [DEB_W-1:0]
//   0x8 STAT RO  filtered levels (writes ignored, no fault)
//   0xC EVT  W1C sticky event flags
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   p_addr/p_w_rb/p_acc/p_wdata/p_req   bus request side
//   p_rdata/p_resp/p_fault              bus response, one cycle after p_req
//   irq_raw            asynchronous raw interrupt lines
//   irq_evt            registered one-cycle event pulses
// ---------------------------------------------------------------------------
module int_src_conditioner #(
  parameter int unsigned EXT_INT_SRC_NUM = 8,
  parameter int unsigned SRC_NUM         = EXT_INT_SRC_NUM,
  parameter int unsigned DEB_W           = 8,
  parameter int unsigned XLEN            = 32,
  parameter int unsigned BUS_WIDTH       = 32,
  parameter int unsigned BUS_ACC_CNT     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [XLEN-1:0]                p_addr,
  input  logic                           p_w_rb,
  input  logic [$clog2(BUS_ACC_CNT)-1:0] p_acc,
  input  logic [BUS_WIDTH-1:0]           p_wdata,
  output logic [BUS_WIDTH-1:0]           p_rdata,
  input  logic                           p_req,
  output logic                           p_resp,
  output logic                           p_fault,
  input  logic [SRC_NUM-1:0]             irq_raw,
  output logic [SRC_NUM-1:0]             irq_evt
);

  localparam int unsigned     ACC_W    = $clog2(BUS_ACC_CNT);
  localparam logic [ACC_W-1:0] ACC_WORD = ACC_W'(32'd2);

  localparam logic [1:0] REG_CFG  = 2'd0;
  localparam logic [1:0] REG_DEB  = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_EVT  = 2'd3;

  // Synchronizer, debounce and edge-history state
  logic [SRC_NUM-1:0] sync1_r;
  logic [SRC_NUM-1:0] sync2_r;
  logic [DEB_W-1:0]   cnt_r [SRC_NUM];
  logic [SRC_NUM-1:0] filt_r;
  logic [SRC_NUM-1:0] filt_d_r;

  // Software-visible registers
  logic [2*SRC_NUM-1:0] cfg_r;
  logic [DEB_W-1:0]     deb_r;
  logic [SRC_NUM-1:0]   evt_r;

  // Combinational helpers
  logic                 legal_s;
  logic                 wr_cfg_s;
  logic                 wr_deb_s;
  logic                 wr_evt_s;
  logic [SRC_NUM-1:0]   evt_clr_s;
  logic [BUS_WIDTH-1:0] rd_word_s;
  logic [SRC_NUM-1:0]   rise_s;
  logic [SRC_NUM-1:0]   fall_s;
  logic [SRC_NUM-1:0]   hit_s;

  // Upper address bits are not decoded and high write-data bits may have no
  // register behind them; fold them into one deliberately unused net.
  logic unused_s;
  assign unused_s = ^{p_addr, p_wdata};

  // Bus access legality and write-strobe decode
  always_comb begin
    legal_s  = (p_acc == ACC_WORD) && (p_addr[1:0] == 2'b00);
    wr_cfg_s = 1'b0;
    wr_deb_s = 1'b0;
    wr_evt_s = 1'b0;
    if (p_req && p_w_rb && legal_s) begin
      case (p_addr[3:2])
        REG_CFG:  wr_cfg_s = 1'b1;
        REG_DEB:  wr_deb_s = 1'b1;
        REG_STAT: wr_cfg_s = 1'b0;  // read-only: write silently dropped
        REG_EVT:  wr_evt_s = 1'b1;
        default:  wr_cfg_s = 1'b0;
      endcase
    end else begin
      wr_cfg_s = 1'b0;
      wr_deb_s = 1'b0;
      wr_evt_s = 1'b0;
    end
  end

  // W1C clear mask, only meaningful during an EVT write
  always_comb begin
    evt_clr_s = {SRC_NUM{1'b0}};
    if (wr_evt_s) begin
      evt_clr_s = p_wdata[SRC_NUM-1:0];
    end else begin
      evt_clr_s = {SRC_NUM{1'b0}};
    end
  end

  // Read-data mux; unused bits stay zero
  always_comb begin
    rd_word_s = {BUS_WIDTH{1'b0}};
    case (p_addr[3:2])
      REG_CFG:  rd_word_s[2*SRC_NUM-1:0] = cfg_r;
      REG_DEB:  rd_word_s[DEB_W-1:0]     = deb_r;
      REG_STAT: rd_word_s[SRC_NUM-1:0]   = filt_r;
      REG_EVT:  rd_word_s[SRC_NUM-1:0]   = evt_r;
      default:  rd_word_s = {BUS_WIDTH{1'b0}};
    endcase
  end

  // Edge qualification against the per-source mode bits
  always_comb begin
    rise_s = filt_r & ~filt_d_r;
    fall_s = ~filt_r & filt_d_r;
    hit_s  = {SRC_NUM{1'b0}};
    for (int i = 0; i < SRC_NUM; i++) begin
      hit_s[i] = (cfg_r[2*i] & rise_s[i]) | (cfg_r[2*i+1] & fall_s[i]);
    end
  end

  // Bus response: one-cycle strobe with data and fault flag
  always_ff @(posedge clk) begin
    if (rst) begin
      p_resp  <= 1'b0;
      p_fault <= 1'b0;
      p_rdata <= {BUS_WIDTH{1'b0}};
    end else begin
      p_resp  <= p_req;
      p_fault <= p_req & ~legal_s;
      if (p_req && legal_s && !p_w_rb) begin
        p_rdata <= rd_word_s;
      end else begin
        p_rdata <= {BUS_WIDTH{1'b0}};
      end
    end
  end

  // Configuration registers and sticky event flags (a new event beats a clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_r <= {(2*SRC_NUM){1'b0}};
      deb_r <= {DEB_W{1'b0}};
      evt_r <= {SRC_NUM{1'b0}};
    end else begin
      if (wr_cfg_s) begin
        cfg_r <= p_wdata[2*SRC_NUM-1:0];
      end
      if (wr_deb_s) begin
        deb_r <= p_wdata[DEB_W-1:0];
      end
      evt_r <= hit_s | (evt_r & ~evt_clr_s);
    end
  end

  // Two-flop synchronizer for the asynchronous raw lines
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= {SRC_NUM{1'b0}};
      sync2_r <= {SRC_NUM{1'b0}};
    end else begin
      sync1_r <= irq_raw;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: a change must persist for DEB+1 cycles before it reaches the
  // filtered level. The >= compare lets a lowered threshold take effect at
  // once and keeps the counter from ever wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_r <= {SRC_NUM{1'b0}};
      for (int i = 0; i < SRC_NUM; i++) begin
        cnt_r[i] <= {DEB_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < SRC_NUM; i++) begin
        if (sync2_r[i] == filt_r[i]) begin
          cnt_r[i] <= {DEB_W{1'b0}};
        end else if (cnt_r[i] >= deb_r) begin
          filt_r[i] <= sync2_r[i];
          cnt_r[i]  <= {DEB_W{1'b0}};
        end else begin
          cnt_r[i] <= cnt_r[i] + DEB_W'(1'b1);
        end
      end
    end
  end

  // Edge history (kept regardless of CFG) and registered event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_d_r <= {SRC_NUM{1'b0}};
      irq_evt  <= {SRC_NUM{1'b0}};
    end else begin
      filt_d_r <= filt_r;
      irq_evt  <= hit_s;
    end
  end

endmodule
